// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } scan_state_t;

  localparam int unsigned N_INPUTS_DEFAULT      = 4;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 1;

  // Settle counter width; at least one bit even when no settling is needed.
  function automatic int unsigned cnt_width(input int unsigned settle_cycles);
    int unsigned w;
    w = $clog2(settle_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Counts cycles spent on the current mux channel and flags when it has settled.
module settle_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = cnt_width(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Saturate at the settle limit; clear restarts the count for the next channel.
  always_comb begin
    expired = (cnt_q == CntMax);
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans an N-to-1 mux channel by channel, assembles the sampled bits into a word
// and hands it downstream over a valid/ready handshake.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned N_INPUTS      = N_INPUTS_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  localparam int unsigned SEL_W        = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [SEL_W-1:0]    sel,
  input  logic                mux_y,
  output logic [N_INPUTS-1:0] word,
  output logic                valid,
  input  logic                ready,
  output logic                busy
);

  localparam logic [SEL_W-1:0] SelLast = SEL_W'(N_INPUTS - 1);

  scan_state_t         state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_INPUTS-1:0] word_q, word_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                timer_clear;
  logic                settled;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .expired (settled)
  );

  // Next-state, select stepping and word capture.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    word_d      = word_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    // Timer only runs while settling a channel; everywhere else it sits at zero.
    timer_clear = 1'b1;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          sel_d   = '0;
          state_d = SETTLE;
          busy_d  = 1'b1;
        end
      end

      SETTLE: begin
        timer_clear = settled;
        if (settled) begin
          word_d[sel_q] = mux_y;
          if (sel_q == SelLast) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end

      DONE: begin
        if (ready) begin
          valid_d = 1'b0;
          if (start) begin
            // Back-to-back scan: the handshake edge is also the new start edge.
            sel_d   = '0;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign sel   = sel_q;
  assign word  = word_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule
